// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcode and FSM state definitions shared by the ALU share controller
package alu_ctrl_pkg;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4} op_t;
  localparam logic [2:0] OP_MAX = 3'd4;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req : request vector        ptr : index with highest priority
//   gnt : one-hot grant         idx : encoded grant        any : some request valid
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one ALU between NREQ requesters with a tagged valid/ready response
//   req_valid/req_ready/req_a/req_b/req_op : per-requester issue channel (one ready at most)
//   alu_a/alu_b/alu_op : registered operands to the ALU    alu_out : ALU result
//   rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_err : response channel
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][15:0] req_a,
  input  logic [NREQ-1:0][15:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_op,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [2:0]            alu_op,
  input  logic [31:0]           alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);
  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            any;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(gidx), .any(any)
  );
  // rst gating keeps every ready low while reset is held, not just after it lands
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          alu_a  <= req_a[gidx];
          alu_b  <= req_b[gidx];
          alu_op <= req_op[gidx];
          rsp_id <= gidx;
          rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state  <= EXEC;
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_err   <= alu_op > OP_MAX;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: table, directed and randomized checks of alu_share_ctrl against a transaction model
module tb_alu_share_ctrl;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][15:0] req_a, req_b;
  logic [3:0][2:0]  req_op;
  logic [15:0]      alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [31:0]      alu_out;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [31:0]      rsp_data;
  logic [1:0]       rsp_id;
  int checks = 0;
  int errors = 0;

  alu_share_ctrl #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [2:0] op);
    case (op)
      3'd0:    return {15'd0, {1'b0, a} + {1'b0, b}};
      3'd1:    return {16'd0, a} - {16'd0, b};
      3'd2:    return {16'd0, a & b};
      3'd3:    return {16'd0, a | b};
      3'd4:    return {16'd0, a ^ b};
      default: return 32'd0;
    endcase
  endfunction

  // the external ALU that the controller drives
  assign alu_out = alu_fn(alu_a, alu_b, alu_op);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t tbl[7];

  int w, last, g, mptr, age, pid;
  bit pend, perr;
  logic [31:0] pdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 16'hFFFF, 16'h0001, 3'd0, 32'h0001_0000, 1'b0};
    tbl[1] = '{2, 16'h0003, 16'h0005, 3'd1, 32'hFFFF_FFFE, 1'b0};
    tbl[2] = '{1, 16'h1234, 16'h5678, 3'd6, 32'h0000_0000, 1'b1};
    tbl[3] = '{3, 16'h00FF, 16'h0F0F, 3'd4, 32'h0000_0FF0, 1'b0};
    tbl[4] = '{1, 16'hF0F0, 16'hFF00, 3'd2, 32'h0000_F000, 1'b0};
    tbl[5] = '{2, 16'h1234, 16'h0F0F, 3'd3, 32'h0000_1F3F, 1'b0};
    tbl[6] = '{3, 16'hFFFF, 16'hFFFF, 3'd0, 32'h0001_FFFE, 1'b0};

    rst = 1'b1;
    clear_reqs();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // table: single requester per operation, full protocol timing
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req_valid = 4'(1 << tbl[v].id);
      req_a[tbl[v].id] = tbl[v].a;
      req_b[tbl[v].id] = tbl[v].b;
      req_op[tbl[v].id] = tbl[v].op;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(1 << tbl[v].id));
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("tbl_exec_ready", 32'(req_ready), 32'd0);
      chk("tbl_exec_valid", 32'(rsp_valid), 32'd0);
      chk("tbl_alu_a", 32'(alu_a), 32'(tbl[v].a));
      chk("tbl_alu_b", 32'(alu_b), 32'(tbl[v].b));
      chk("tbl_alu_op", 32'(alu_op), 32'(tbl[v].op));
      @(negedge clk);
      #1;
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_rsp_data", rsp_data, tbl[v].data);
      chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[v].id));
      chk("tbl_rsp_err", 32'(rsp_err), 32'(tbl[v].err));
      @(negedge clk);
      #1;
      chk("tbl_rsp_done", 32'(rsp_valid), 32'd0);
    end

    // backpressure: response held while rsp_ready low, other requests blocked
    do_reset();
    clear_reqs();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_a[2] = 16'd3;
    req_b[2] = 16'd5;
    req_op[2] = 3'd1;
    #1;
    chk("hold_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    chk("hold_exec_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, 32'hFFFF_FFFE);
      chk("hold_id", 32'(rsp_id), 32'd2);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("hold_after_hs", 32'(req_ready), 32'b1000);
    chk("hold_valid_drop", 32'(rsp_valid), 32'd0);

    // async reset during EXEC discards the operation
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst_exec_state", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_alu_a", 32'(alu_a), 32'd0);
    chk("rst_async_alu_op", 32'(alu_op), 32'd0);
    chk("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_async_rsp_data", rsp_data, 32'd0);
    chk("rst_async_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_no_response", 32'(rsp_valid), 32'd0);

    // fairness: all valid, rsp_ready held high
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 16'(i + 1);
      req_b[i] = 16'd1;
      req_op[i] = 3'd0;
    end
    req_valid = 4'hF;
    last = 0;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      #1;
      while (req_ready == 0 && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("fair_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      @(negedge clk);
    end
    req_valid = '0;

    // randomized run against a transaction-level model
    do_reset();
    mptr = 0;
    pend = 0;
    age = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        req_a[i] = 16'($urandom);
        req_b[i] = 16'($urandom);
        req_op[i] = 3'($urandom_range(0, 7));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (!pend)
        for (int i = 0; i < 4; i++)
          if (g < 0 && req_valid[(mptr + i) % 4]) g = (mptr + i) % 4;
      chk("rnd_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
      chk("rnd_valid", 32'(rsp_valid), 32'(pend && age >= 2));
      if (pend && age >= 2) begin
        chk("rnd_data", rsp_data, pdata);
        chk("rnd_id", 32'(rsp_id), 32'(pid));
        chk("rnd_err", 32'(rsp_err), 32'(perr));
        if (rsp_ready) pend = 0;
      end else if (pend) begin
        age++;
      end else if (g >= 0) begin
        pend = 1;
        age = 1;
        pdata = alu_fn(req_a[g], req_b[g], req_op[g]);
        pid = g;
        perr = req_op[g] > 3'd4;
        mptr = (g + 1) % 4;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
